lcd_8080_wr_engine: RTL and testbench

- Hardware write engine for the 8080-style parallel LCD bus; sits directly downstream of the AHB-Lite LCD register block and owns the physical LCD pins.
- In software mode it passes the register block's bit-bang pin values through to the pins.
- In hardware mode it drains a command/data FIFO and generates CS/RS/WR/DATA strobes with programmable timing.
- It also runs the panel reset pulse sequence when the register block fires its init strobe.

---
 rtl/lcd_8080_wr_engine.sv | 157 +++++++++++++++
 tb/tb_lcd_8080_wr_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_8080_wr_engine.sv
// 8080 LCD write engine: sw pin pass-through, or FIFO-fed CS/RS/WR strobes plus panel reset sequencing.
// All pins registered (1-cycle latency); wr_ready_o drops while the FIFO is full; one word costs 1+WR_LOW_CYC+WR_HIGH_CYC cycles.
module lcd_8080_wr_engine #(
  parameter int FIFO_DEPTH   = 8,
  parameter int WR_LOW_CYC   = 2,
  parameter int WR_HIGH_CYC  = 2,
  parameter int RST_LOW_CYC  = 16,
  parameter int RST_WAIT_CYC = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        mode_i,
  input  logic        ini_i,
  input  logic        wr_valid_i,
  input  logic        wr_rs_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_ready_o,
  output logic        busy_o,
  input  logic        sw_cs_i,
  input  logic        sw_rs_i,
  input  logic        sw_wr_i,
  input  logic        sw_rd_i,
  input  logic        sw_rst_i,
  input  logic [15:0] sw_data_i,
  output logic        LCD_CS,
  output logic        LCD_RS,
  output logic        LCD_WR,
  output logic        LCD_RD,
  output logic        LCD_RST,
  output logic [15:0] LCD_DATA
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT      = FIFO_DEPTH[AW:0];
  localparam logic [15:0] WR_LO_LAST    = 16'(WR_LOW_CYC - 1);
  localparam logic [15:0] WR_HI_LAST    = 16'(WR_HIGH_CYC - 1);
  localparam logic [15:0] RST_LO_LAST   = 16'(RST_LOW_CYC - 1);
  localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WR_LO, S_WR_HI, S_RST_LO, S_RST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [15:0]   cnt_q, cnt_d;
  logic          pend_q;
  logic          word_rs_q, word_rs_d;
  logic [15:0]   word_data_q, word_data_d;
  logic          eng_cs, eng_wr, eng_rst;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign push       = wr_valid_i & ~full;
  assign wr_ready_o = ~full;
  assign busy_o     = (state_q != S_IDLE) | ~empty | pend_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= {wr_rs_i, wr_data_i};
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_RST_LO;
        end else if (mode_i && !empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP:  state_d = S_WR_LO;
      S_WR_LO:  if (cnt_q == WR_LO_LAST) state_d = S_WR_HI;
      S_WR_HI: begin
        if (cnt_q == WR_HI_LAST) begin
          // Pending init wins over the next word; it is picked up from IDLE.
          if (!pend_q && mode_i && !empty) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_RST_LO:   if (cnt_q == RST_LO_LAST) state_d = S_RST_WAIT;
      S_RST_WAIT: if (cnt_q == RST_WAIT_LAST) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    cnt_d       = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    word_rs_d   = pop ? mem_q[rd_ptr_q][16]   : word_rs_q;
    word_data_d = pop ? mem_q[rd_ptr_q][15:0] : word_data_q;
    eng_cs      = !(state_d == S_SETUP || state_d == S_WR_LO || state_d == S_WR_HI);
    eng_wr      = (state_d != S_WR_LO);
    eng_rst     = (state_d != S_RST_LO);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      word_rs_q   <= 1'b0;
      word_data_q <= '0;
      LCD_CS      <= 1'b1;
      LCD_RS      <= 1'b0;
      LCD_WR      <= 1'b1;
      LCD_RD      <= 1'b1;
      LCD_RST     <= 1'b0;
      LCD_DATA    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_rs_q   <= word_rs_d;
      word_data_q <= word_data_d;
      // A pulse arriving during the reset sequence re-arms it once more.
      pend_q      <= ini_i | (pend_q & ~(state_q == S_IDLE && state_d == S_RST_LO));
      if (mode_i) begin
        LCD_CS   <= eng_cs;
        LCD_RS   <= word_rs_d;
        LCD_WR   <= eng_wr;
        LCD_RD   <= 1'b1;
        LCD_RST  <= eng_rst;
        LCD_DATA <= word_data_d;
      end else begin
        LCD_CS   <= sw_cs_i;
        LCD_RS   <= sw_rs_i;
        LCD_WR   <= sw_wr_i;
        LCD_RD   <= sw_rd_i;
        LCD_RST  <= sw_rst_i;
        LCD_DATA <= sw_data_i;
      end
    end
  end

endmodule

// File: tb/tb_lcd_8080_wr_engine.sv
// Directed bench for lcd_8080_wr_engine: pin monitor records strobe run lengths and written words.
module tb_lcd_8080_wr_engine;

  logic        HCLK = 1'b0;
  logic        HRESETn, mode_i, ini_i, wr_valid_i, wr_rs_i;
  logic [15:0] wr_data_i;
  logic        wr_ready_o, busy_o;
  logic        sw_cs_i, sw_rs_i, sw_wr_i, sw_rd_i, sw_rst_i;
  logic [15:0] sw_data_i;
  logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST;
  logic [15:0] LCD_DATA;

  lcd_8080_wr_engine dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mode_i(mode_i), .ini_i(ini_i),
    .wr_valid_i(wr_valid_i), .wr_rs_i(wr_rs_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .busy_o(busy_o),
    .sw_cs_i(sw_cs_i), .sw_rs_i(sw_rs_i), .sw_wr_i(sw_wr_i), .sw_rd_i(sw_rd_i),
    .sw_rst_i(sw_rst_i), .sw_data_i(sw_data_i),
    .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
    .LCD_RST(LCD_RST), .LCD_DATA(LCD_DATA)
  );

  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pin monitor
  logic [16:0] cap_q[$];
  int cs_cnt = 0, cs_last = -1, wr_cnt = 0, wr_last = -1;
  int rst_cnt = 0, rst_last = -1, rst_hi = 0;
  int wr_fall_cs = -1, wr_fall_rst = -1, unstable = 0;
  logic prev_cs = 1'b1, prev_wr = 1'b1, prev_rst = 1'b0;
  logic [16:0] prev_word = '0;

  always @(negedge HCLK) begin
    if (!LCD_CS) cs_cnt++;
    else if (!prev_cs) begin cs_last = cs_cnt; cs_cnt = 0; end
    if (!LCD_WR) wr_cnt++;
    else if (!prev_wr) begin wr_last = wr_cnt; wr_cnt = 0; end
    if (!LCD_RST) begin
      rst_cnt++;
      rst_hi = 0;
    end else begin
      if (!prev_rst) begin rst_last = rst_cnt; rst_cnt = 0; end
      rst_hi++;
    end
    if (prev_wr && !LCD_WR) begin
      if (wr_fall_cs < 0)  wr_fall_cs  = cs_cnt;
      if (wr_fall_rst < 0) wr_fall_rst = rst_hi;
    end
    if (mode_i && !LCD_CS && (!LCD_WR || !prev_wr) && ({LCD_RS, LCD_DATA} != prev_word))
      unstable++;
    if (mode_i && !prev_wr && LCD_WR && !LCD_CS)
      cap_q.push_back({LCD_RS, LCD_DATA});
    prev_cs   = LCD_CS;
    prev_wr   = LCD_WR;
    prev_rst  = LCD_RST;
    prev_word = {LCD_RS, LCD_DATA};
  end

  task automatic clr_mon();
    cap_q.delete();
    cs_cnt = 0; cs_last = -1; wr_cnt = 0; wr_last = -1;
    rst_cnt = 0; rst_last = -1; wr_fall_cs = -1; wr_fall_rst = -1; unstable = 0;
  endtask

  function automatic logic [16:0] get_cap(input int i);
    return (i < cap_q.size()) ? cap_q[i] : 17'bx;
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
    #1;
  endtask

  task automatic push_word(input logic rs, input logic [15:0] d);
    wr_valid_i = 1'b1;
    wr_rs_i    = rs;
    wr_data_i  = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int k;
    k = 0;
    smp();
    while (!(cap_q.size() >= n && LCD_CS === 1'b1) && k < 2000) begin
      smp();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 2000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1);
  end

  initial begin
    int k;
    HRESETn = 1'b0; mode_i = 1'b0; ini_i = 1'b0;
    wr_valid_i = 1'b0; wr_rs_i = 1'b0; wr_data_i = '0;
    sw_cs_i = 1'b1; sw_rs_i = 1'b0; sw_wr_i = 1'b1; sw_rd_i = 1'b1; sw_rst_i = 1'b1;
    sw_data_i = '0;
    repeat (3) tick();

    // Reset state
    smp();
    chk("rst_cs",    LCD_CS,     1);
    chk("rst_wr",    LCD_WR,     1);
    chk("rst_rd",    LCD_RD,     1);
    chk("rst_rst",   LCD_RST,    0);
    chk("rst_rs",    LCD_RS,     0);
    chk("rst_data",  LCD_DATA,   0);
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_busy",  busy_o,     0);
    tick();
    HRESETn = 1'b1;

    // Single word timing
    mode_i = 1'b1;
    tick(); tick();
    clr_mon();
    push_word(1'b1, 16'h1234);
    wait_done(1, "t1");
    chk("t1_cs_low",   cs_last,    5);
    chk("t1_wr_low",   wr_last,    2);
    chk("t1_wr_delay", wr_fall_cs, 2);
    chk("t1_word",     get_cap(0), 17'h11234);
    chk("t1_busy",     busy_o,     0);
    chk("t1_stable",   unstable,   0);

    // Fill in software mode, then drain back-to-back
    mode_i = 1'b0;
    tick();
    clr_mon();
    for (int i = 0; i < 9; i++) begin
      wr_valid_i = 1'b1;
      wr_rs_i    = i[0];
      wr_data_i  = 16'hA000 + 16'(i);
      smp();
      chk($sformatf("t2_ready%0d", i), wr_ready_o, 32'(i < 8));
      tick();
    end
    smp();
    chk("t2_held",    wr_ready_o, 0);
    chk("t2_busy",    busy_o,     1);
    chk("t2_no_pop",  cap_q.size(), 0);
    wr_valid_i = 1'b0;
    mode_i = 1'b1;
    wait_done(8, "t2");
    chk("t2_cs_low", cs_last, 40);
    chk("t2_count",  cap_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_word%0d", i), get_cap(i), {i[0], 16'hA000 + 16'(i)});
    chk("t2_stable", unstable, 0);
    push_word(1'b0, 16'hA008);
    wait_done(9, "t2b");
    chk("t2_word8",   get_cap(8), 17'h0A008);
    chk("t2_cs_low9", cs_last,    5);
    chk("t2_busy_end", busy_o,    0);

    // Init sequence with two words queued
    mode_i = 1'b0;
    tick();
    clr_mon();
    push_word(1'b0, 16'hB001);
    push_word(1'b1, 16'hB002);
    ini_i = 1'b1;
    tick();
    ini_i  = 1'b0;
    mode_i = 1'b1;
    wait_done(2, "t3");
    chk("t3_rst_low",  rst_last,    16);
    chk("t3_wr_after", wr_fall_rst, 35);
    chk("t3_word0",    get_cap(0),  17'h0B001);
    chk("t3_word1",    get_cap(1),  17'h1B002);
    chk("t3_busy",     busy_o,      0);

    // Software pass-through
    mode_i = 1'b0;
    tick();
    sw_data_i = 16'hABCD; sw_wr_i = 1'b0; sw_cs_i = 1'b0; sw_rs_i = 1'b1; sw_rd_i = 1'b0;
    smp();
    chk("t4_latency", LCD_CS, 1);
    smp();
    chk("t4_data",  LCD_DATA,   16'hABCD);
    chk("t4_wr",    LCD_WR,     0);
    chk("t4_cs",    LCD_CS,     0);
    chk("t4_rs",    LCD_RS,     1);
    chk("t4_rd",    LCD_RD,     0);
    chk("t4_busy",  busy_o,     0);
    chk("t4_ready", wr_ready_o, 1);
    sw_data_i = '0; sw_wr_i = 1'b1; sw_cs_i = 1'b1; sw_rs_i = 1'b0; sw_rd_i = 1'b1;
    tick(); tick();

    // Reset during WR_LO
    mode_i = 1'b1;
    tick();
    clr_mon();
    push_word(1'b0, 16'hC0DE);
    push_word(1'b1, 16'hC0DF);
    k = 0;
    smp();
    while (LCD_WR !== 1'b0 && k < 50) begin
      smp();
      k++;
    end
    chk("t5_wr_lo_seen", LCD_WR, 0);
    HRESETn = 1'b0;
    tick();
    smp();
    chk("t5_wr",   LCD_WR,   1);
    chk("t5_cs",   LCD_CS,   1);
    chk("t5_rst",  LCD_RST,  0);
    chk("t5_data", LCD_DATA, 0);
    tick();
    HRESETn = 1'b1;
    tick();
    smp();
    chk("t5_busy",    busy_o,     0);
    chk("t5_ready",   wr_ready_o, 1);
    chk("t5_rst_rel", LCD_RST,    1);
    repeat (10) smp();
    chk("t5_no_words", cap_q.size(), 0);
    chk("t5_cs_idle",  LCD_CS,       1);

    // Push against a full FIFO in the cycle it pops
    mode_i = 1'b0;
    tick();
    clr_mon();
    for (int i = 0; i < 8; i++)
      push_word(i[0], 16'hD000 + 16'(i));
    mode_i = 1'b1;
    wr_valid_i = 1'b1; wr_rs_i = 1'b0; wr_data_i = 16'hD008;
    smp();
    chk("t6_reject", wr_ready_o, 0);
    tick();
    smp();
    chk("t6_free", wr_ready_o, 1);
    tick();
    wr_valid_i = 1'b0;
    smp();
    chk("t6_refull", wr_ready_o, 0);
    wait_done(9, "t6");
    chk("t6_count",  cap_q.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("t6_word%0d", i), get_cap(i), {i[0], 16'hD000 + 16'(i)});
    chk("t6_cs_low", cs_last,  45);
    chk("t6_stable", unstable, 0);
    chk("t6_busy",   busy_o,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
